// File: rtl/ssd_scan_buffer_pkg.sv
// rtl/ssd_scan_buffer_pkg.sv - shared constants and types for the seven-segment scan buffer
package ssd_pkg;
    localparam int SEG_W = 8;
    typedef logic [SEG_W-1:0] seg_pat_t;

    localparam seg_pat_t SSD_BLANK  = 8'h00;
    localparam logic     MODE_SHIFT = 1'b0;
    localparam logic     MODE_ADDR  = 1'b1;
    localparam int       PWM_STEPS  = 16;
    localparam int       SCAN_DIV_DEFAULT = 100000;
endpackage

// File: rtl/ssd_scan_buffer_if.sv
// rtl/ssd_scan_buffer_if.sv - write/brightness inputs and display pin outputs of the scan buffer
interface ssd_scan_buffer_if import ssd_pkg::*; #(
    parameter int NUM_DIGITS = 4
);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    seg_pat_t                wr_val;
    logic [IDX_W-1:0]        wr_addr;
    logic                    wr_mode;
    logic                    write;
    logic                    clear;
    logic [3:0]              bright;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame;

    modport master (
        output wr_val, wr_addr, wr_mode, write, clear, bright,
        input  seg, dp, an, frame
    );

    modport slave (
        input  wr_val, wr_addr, wr_mode, write, clear, bright,
        output seg, dp, an, frame
    );
endinterface

// File: rtl/ssd_scan_timer.sv
// rtl/ssd_scan_timer.sv - digit slot / PWM phase / digit index counters for the scan
module ssd_scan_timer import ssd_pkg::*; #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = SCAN_DIV_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [$clog2(NUM_DIGITS)-1:0] idx,
    output logic [3:0]                    phase,
    output logic                          adv,
    output logic                          frame
);
    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int SUB_MAX = SCAN_DIV / PWM_STEPS - 1;
    localparam int SUB_W   = (SUB_MAX > 0) ? $clog2(SUB_MAX + 1) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_MAX);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [SUB_W-1:0] sub_cnt;
    logic             sub_wrap;

    assign sub_wrap = (sub_cnt == SUB_LAST);
    assign adv      = sub_wrap && (phase == 4'd15);

    // frame is high during the first cycle spent on digit 0 after a wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            sub_cnt <= '0;
            phase   <= '0;
            idx     <= '0;
            frame   <= 1'b0;
        end else begin
            frame   <= adv && (idx == IDX_LAST);
            sub_cnt <= sub_wrap ? '0 : sub_cnt + 1'b1;
            if (sub_wrap)
                phase <= phase + 4'd1;
            if (adv)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
    end
endmodule

// File: rtl/ssd_scan_buffer.sv
// rtl/ssd_scan_buffer.sv - multiplexed seven-segment driver with digit buffer and per-digit PWM
module ssd_scan_buffer import ssd_pkg::*; #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = SCAN_DIV_DEFAULT,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input logic               clk,
    input logic               rst,
    ssd_scan_buffer_if.slave  bus
);
    localparam int   IDX_W = $clog2(NUM_DIGITS);
    localparam logic POL   = ACTIVE_LOW;

    logic                  write_d;
    logic                  wpulse;
    seg_pat_t              digits [NUM_DIGITS];
    logic [3:0]            bright_q;
    logic [IDX_W-1:0]      idx;
    logic [3:0]            phase;
    logic                  adv;
    logic                  tmr_frame;
    logic                  lit;
    seg_pat_t              pat;
    logic [NUM_DIGITS-1:0] an_onehot;

    ssd_scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .idx   (idx),
        .phase (phase),
        .adv   (adv),
        .frame (tmr_frame)
    );

    // Edge detector keeps tracking through reset so a level held across reset is not a new request
    always_ff @(posedge clk) write_d <= bus.write;
    assign wpulse = bus.write & ~write_d;

    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            for (int k = 0; k < NUM_DIGITS; k++)
                digits[k] <= SSD_BLANK;
        end else if (wpulse) begin
            if (bus.wr_mode == MODE_SHIFT) begin
                for (int k = NUM_DIGITS - 1; k > 0; k--)
                    digits[k] <= digits[k-1];
                digits[0] <= bus.wr_val;
            end else if (int'(bus.wr_addr) < NUM_DIGITS) begin
                digits[bus.wr_addr] <= bus.wr_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            bright_q <= 4'd15;
        else if (adv)
            bright_q <= bus.bright;
    end

    always_comb begin
        lit            = (phase <= bright_q);
        an_onehot      = '0;
        an_onehot[idx] = 1'b1;
        pat            = lit ? digits[idx] : SSD_BLANK;
    end

    // Polarity is applied as the last step before the pin registers
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.seg   <= {7{POL}};
            bus.dp    <= POL;
            bus.an    <= {NUM_DIGITS{POL}};
            bus.frame <= 1'b0;
        end else begin
            bus.seg   <= pat[6:0] ^ {7{POL}};
            bus.dp    <= pat[7] ^ POL;
            bus.an    <= (lit ? an_onehot : '0) ^ {NUM_DIGITS{POL}};
            bus.frame <= tmr_frame;
        end
    end
endmodule

// File: tb/tb_ssd_scan_buffer.sv
// tb/tb_ssd_scan_buffer.sv - self-checking bench for ssd_scan_buffer (4-digit active-low and 3-digit active-high builds)
module tb_ssd_scan_buffer;
    localparam int SD = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] wr_val = 8'hFF;
    logic [1:0] wr_addr = 2'd0;
    logic       wr_mode = 1'b0;
    logic       write = 1'b1;
    logic       clear = 1'b0;
    logic [3:0] bright = 4'd15;

    always #5 clk = ~clk;

    ssd_scan_buffer_if #(.NUM_DIGITS(4)) bus_a ();
    ssd_scan_buffer_if #(.NUM_DIGITS(3)) bus_b ();

    assign bus_a.wr_val = wr_val;   assign bus_b.wr_val = wr_val;
    assign bus_a.wr_addr = wr_addr; assign bus_b.wr_addr = wr_addr;
    assign bus_a.wr_mode = wr_mode; assign bus_b.wr_mode = wr_mode;
    assign bus_a.write = write;     assign bus_b.write = write;
    assign bus_a.clear = clear;     assign bus_b.clear = clear;
    assign bus_a.bright = bright;   assign bus_b.bright = bright;

    ssd_scan_buffer #(.NUM_DIGITS(4), .SCAN_DIV(SD), .ACTIVE_LOW(1'b1)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave));
    ssd_scan_buffer #(.NUM_DIGITS(3), .SCAN_DIV(SD), .ACTIVE_LOW(1'b0)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave));

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference model: scan position derived from elapsed cycles since reset
    int         n_dig   [2] = '{4, 3};
    bit         act_low [2] = '{1'b1, 1'b0};
    logic [7:0] m_buf   [2][4];
    int         m_t     [2];
    logic [3:0] m_bq    [2];
    logic       m_wd = 1'b0;
    bit         m_valid = 1'b0;
    logic [7:0] exp_pat [2];
    logic [3:0] exp_an  [2];
    logic       exp_frm [2];

    task automatic model_step();
        int ph;
        int dg;
        bit on;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                exp_pat[k] = 8'h00;
                exp_an[k]  = 4'h0;
                exp_frm[k] = 1'b0;
                m_t[k]     = 0;
                m_bq[k]    = 4'd15;
                for (int j = 0; j < 4; j++) m_buf[k][j] = 8'h00;
            end else begin
                ph = (m_t[k] % SD) / (SD / 16);
                dg = (m_t[k] / SD) % n_dig[k];
                on = (ph <= int'(m_bq[k]));
                exp_an[k]  = on ? (4'b0001 << dg) : 4'b0000;
                exp_pat[k] = on ? m_buf[k][dg] : 8'h00;
                exp_frm[k] = (m_t[k] > 0) && (m_t[k] % (SD * n_dig[k]) == 0);
                if (clear) begin
                    for (int j = 0; j < 4; j++) m_buf[k][j] = 8'h00;
                end else if (write && !m_wd) begin
                    if (wr_mode == 1'b0) begin
                        for (int j = n_dig[k] - 1; j > 0; j--) m_buf[k][j] = m_buf[k][j-1];
                        m_buf[k][0] = wr_val;
                    end else if (int'(wr_addr) < n_dig[k]) begin
                        m_buf[k][wr_addr] = wr_val;
                    end
                end
                if ((m_t[k] + 1) % SD == 0) m_bq[k] = bright;
                m_t[k]++;
            end
        end
        m_wd = write;
        if (rst) m_valid = 1'b1;
    endtask

    function automatic logic [12:0] exp_word(input int k);
        logic [3:0] msk = (k == 0) ? 4'hF : 4'h7;
        logic       p   = act_low[k];
        return {exp_pat[k][6:0] ^ {7{p}}, exp_pat[k][7] ^ p, (exp_an[k] ^ {4{p}}) & msk, exp_frm[k]};
    endfunction

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            check("model_a", {bus_a.seg, bus_a.dp, bus_a.an, bus_a.frame}, exp_word(0));
            check("model_b", {bus_b.seg, bus_b.dp, 1'b0, bus_b.an, bus_b.frame}, exp_word(1));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_write(input logic mode, input logic [1:0] addr, input logic [7:0] val);
        wr_mode = mode; wr_addr = addr; wr_val = val; write = 1'b1;
        tick(1);
        write = 1'b0;
        tick(1);
    endtask

    function automatic logic [3:0] cur_an(input int k);
        return (k == 0) ? bus_a.an : {1'b0, bus_b.an};
    endfunction

    task automatic wait_an(input string tag, input int k, input logic [3:0] pat);
        int w = 0;
        while (cur_an(k) !== pat && w < 400) begin tick(1); w++; end
        check(tag, cur_an(k), pat);
    endtask

    task automatic wait_frame(input string tag);
        int w = 0;
        tick(1);
        while (bus_a.frame !== 1'b1 && w < 400) begin tick(1); w++; end
        check(tag, bus_a.frame, 1'b1);
    endtask

    int cnt [4];
    int n_onehot;
    int n_nonblank;

    task automatic count_frame(input int chg_at, input logic [3:0] chg_val);
        for (int d = 0; d < 4; d++) cnt[d] = 0;
        n_onehot = 0;
        n_nonblank = 0;
        for (int i = 0; i < 128; i++) begin
            if (i == chg_at) bright = chg_val;
            for (int d = 0; d < 4; d++) if (bus_a.an[d] == 1'b0) cnt[d]++;
            if ($countones(~bus_a.an) == 1) n_onehot++;
            if (bus_a.seg != 7'h7F || bus_a.dp != 1'b1 || bus_b.seg != 7'h00) n_nonblank++;
            tick(1);
        end
    endtask

    initial begin
        int w;
        int r;
        tick(3);
        check("rst_an_a", bus_a.an, 4'hF);
        check("rst_seg_a", bus_a.seg, 7'h7F);
        check("rst_dp_a", bus_a.dp, 1'b1);
        check("rst_frame_a", bus_a.frame, 1'b0);
        check("rst_an_b", bus_b.an, 3'b000);
        check("rst_seg_b", bus_b.seg, 7'h00);

        // write held high across reset release must not write
        rst = 1'b0;
        tick(40);
        check("held_write_seg", bus_a.seg, 7'h7F);
        write = 1'b0;
        tick(1);

        pulse_write(1'b0, 2'd0, 8'h06);
        pulse_write(1'b0, 2'd0, 8'h5B);
        pulse_write(1'b0, 2'd0, 8'h4F);
        pulse_write(1'b0, 2'd0, 8'h66);
        pulse_write(1'b0, 2'd0, 8'h6D);
        wait_an("shift_dig0_an", 0, 4'b1110);
        check("shift_dig0_seg", bus_a.seg, 7'h12);

        wr_val = 8'h3F; write = 1'b1;
        tick(10);
        write = 1'b0;
        tick(1);
        wait_an("hold_dig1_an", 0, 4'b1101);
        check("hold_dig1_seg", bus_a.seg, 7'h12);
        wait_an("hold_dig3_an", 0, 4'b0111);
        check("hold_dig3_seg", bus_a.seg, 7'h30);

        pulse_write(1'b1, 2'd2, 8'h80);
        pulse_write(1'b1, 2'd3, 8'hFF);
        wait_an("addr_dig2_an", 0, 4'b1011);
        check("addr_dig2_dp", bus_a.dp, 1'b0);
        check("addr_dig2_seg", bus_a.seg, 7'h7F);
        wait_an("addr_b_dig2_an", 1, 4'b0100);
        check("addr_b_dig2_seg", bus_b.seg, 7'h00);
        check("addr_b_dig2_dp", bus_b.dp, 1'b1);

        bright = 4'd3;
        wait_frame("frame_wait1");
        wait_frame("frame_wait2");
        count_frame(-1, 4'd0);
        for (int d = 0; d < 4; d++) check("duty3_digit", cnt[d], 8);
        check("duty3_onehot", n_onehot, 32);

        bright = 4'd15;
        wait_frame("frame_wait3");
        wait_frame("frame_wait4");
        count_frame(-1, 4'd0);
        check("duty15_onehot", n_onehot, 128);

        wait_frame("frame_wait5");
        count_frame(5, 4'd0);
        check("midslot_dig0", cnt[0], 32);
        check("midslot_dig1", cnt[1], 2);
        check("midslot_dig3", cnt[3], 2);

        bright = 4'd15;
        wait_frame("frame_wait6");
        wait_frame("frame_wait7");
        wr_mode = 1'b0; wr_val = 8'hFF;
        clear = 1'b1; write = 1'b1;
        tick(1);
        clear = 1'b0; write = 1'b0;
        tick(1);
        count_frame(-1, 4'd15);
        check("clear_wins_blank", n_nonblank, 0);
        check("clear_wins_onehot", n_onehot, 128);

        pulse_write(1'b0, 2'd0, 8'h7F);
        wait_frame("frame_wait8");
        tick(14);
        rst = 1'b1;
        tick(1);
        check("midreset_an", bus_a.an, 4'hF);
        check("midreset_seg", bus_a.seg, 7'h7F);
        rst = 1'b0;
        tick(1);
        check("restart_an", bus_a.an, 4'b1110);
        check("restart_seg", bus_a.seg, 7'h7F);
        w = 0;
        while (bus_a.frame !== 1'b1 && w < 400) begin tick(1); w++; end
        check("frame_period", w, 128);

        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 19);
            if (r < 10) begin
                pulse_write(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom));
            end else if (r < 13) begin
                bright = 4'($urandom_range(0, 15));
                tick(1);
            end else if (r < 14) begin
                clear = 1'b1;
                tick($urandom_range(1, 2));
                clear = 1'b0;
            end else if (r < 15) begin
                wr_mode = 1'($urandom_range(0, 1)); wr_val = 8'($urandom);
                clear = 1'b1; write = 1'b1;
                tick(1);
                clear = 1'b0; write = 1'b0;
                tick(1);
            end else if (r < 19) begin
                tick($urandom_range(1, 40));
            end else begin
                rst = 1'b1; write = 1'($urandom_range(0, 1));
                tick($urandom_range(1, 2));
                rst = 1'b0;
                tick(1);
                write = 1'b0;
                tick(1);
            end
        end
        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
